// File: rtl/iob_diff_arb_if.sv
// Request/response bundle for the shared differentiator: N_CH sample
// sources on the request side, one difference consumer on the output side.
interface iob_diff_arb_if #(
    parameter int DATA_W = 32,
    parameter int N_CH   = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]        req_valid;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   out_first;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_ch, out_first
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_ch, out_first
    );
endinterface

// File: rtl/iob_diff_arb.sv
// Time-multiplexed differentiator: round-robin grant of one channel per cycle,
// output = granted sample minus that channel's previous sample.
module iob_diff_arb #(
    parameter int DATA_W = 32,
    parameter int N_CH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    iob_diff_arb_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);

    logic [DATA_W-1:0] hist [N_CH];
    logic [DATA_W-1:0] data_arr [N_CH];
    logic [N_CH-1:0]   first_pend;
    logic [CH_W-1:0]   ptr;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              out_first_q;

    logic              slot_free;
    logic              found;
    logic              grant_en;
    logic [CH_W-1:0]   gnt;
    logic [CH_W:0]     idx;
    logic [CH_W-1:0]   cidx;
    logic [N_CH-1:0]   ready;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan ptr, ptr+1, ... wrapping at N_CH; the first valid channel wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        cidx  = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end
            cidx = idx[CH_W-1:0];
            if (!found && bus.req_valid[cidx]) begin
                found = 1'b1;
                gnt   = cidx;
            end
        end
    end

    assign slot_free = !out_valid_q || bus.out_ready;
    assign grant_en  = found && slot_free && !clr && !rst;

    always_comb begin
        ready = '0;
        if (grant_en) begin
            ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                hist[i] <= '0;
            end
            first_pend  <= '1;
            ptr         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_first_q <= 1'b0;
        end else begin
            if (clr) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    hist[i] <= '0;
                end
                first_pend <= '1;
                ptr        <= '0;
            end else if (grant_en) begin
                hist[gnt]       <= data_arr[gnt];
                first_pend[gnt] <= 1'b0;
                ptr             <= (gnt == CH_W'(N_CH-1)) ? '0 : gnt + 1'b1;
            end

            // Output stage is independent of clr so a pending result still drains.
            if (grant_en) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_arr[gnt] - hist[gnt];
                out_ch_q    <= gnt;
                out_first_q <= first_pend[gnt];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_first = out_first_q;
endmodule
